// File: rtl/exception_sequencer.sv
// Exception entry sequencer: prioritises exception requests, saves the EPC,
// fetches the handler address from the vector table and loads it into the PC.
//
// Ports:
//   clk               - single clock, rising edge
//   reset             - asynchronous, active-low reset
//   exc_opcode        - invalid-opcode request (highest priority, cause 00)
//   exc_overflow      - arithmetic-overflow request (cause 01)
//   exc_divzero       - divide-by-zero request (lowest priority, cause 10)
//   pc_in             - current, already incremented PC
//   mem_ack           - vector read complete, mem_data valid
//   mem_data          - vector read data, low byte is the handler address
//   Exception_Control - vector mux select (00->253, 01->254, 10->255)
//   mem_req           - vector read request
//   epc_out / epc_we  - EPC write data / one-cycle write strobe
//   pc_out / pc_we    - handler address / one-cycle PC write strobe
//   busy              - core stall, high outside IDLE
//   cause             - latched cause code
//   abort             - one-cycle pulse when the vector read times out
module exception_sequencer #(
  parameter logic [31:0] EPC_OFFSET  = 32'd4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [31:0] pc_in,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic [1:0]  Exception_Control,
  output logic        mem_req,
  output logic [31:0] epc_out,
  output logic        epc_we,
  output logic [31:0] pc_out,
  output logic        pc_we,
  output logic        busy,
  output logic [1:0]  cause,
  output logic        abort
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAVE = 2'd1,
    REQ  = 2'd2,
    LOAD = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic       w_exc_any;
  logic [1:0] w_cause_sel;
  logic       w_timeout;
  logic       w_unused_data;

  // Only the low byte of the vector entry is a handler address.
  assign w_unused_data = ^mem_data[31:8];

  assign w_exc_any = exc_opcode | exc_overflow | exc_divzero;

  // Fixed priority: opcode > overflow > divzero.
  always_comb begin
    w_cause_sel = 2'b10;
    if (exc_opcode) begin
      w_cause_sel = 2'b00;
    end else if (exc_overflow) begin
      w_cause_sel = 2'b01;
    end
  end

  // Counter holds completed REQ cycles minus one, so this edge ends the last allowed cycle.
  assign w_timeout = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

  // Sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state           <= IDLE;
      r_cnt             <= '0;
      Exception_Control <= 2'b00;
      mem_req           <= 1'b0;
      epc_out           <= 32'd0;
      epc_we            <= 1'b0;
      pc_out            <= 32'd0;
      pc_we             <= 1'b0;
      busy              <= 1'b0;
      cause             <= 2'b00;
      abort             <= 1'b0;
    end else begin
      epc_we <= 1'b0;
      pc_we  <= 1'b0;
      abort  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_exc_any) begin
            r_state           <= SAVE;
            cause             <= w_cause_sel;
            Exception_Control <= w_cause_sel;
            busy              <= 1'b1;
            epc_out           <= pc_in - EPC_OFFSET;
            epc_we            <= 1'b1;
          end
        end
        SAVE: begin
          r_state <= REQ;
          r_cnt   <= '0;
          mem_req <= 1'b1;
        end
        REQ: begin
          // A late ack on the final allowed cycle still completes normally.
          if (mem_ack) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            mem_req <= 1'b0;
            pc_out  <= {24'd0, mem_data[7:0]};
            pc_we   <= 1'b1;
          end else if (w_timeout) begin
            r_state           <= IDLE;
            r_cnt             <= '0;
            mem_req           <= 1'b0;
            busy              <= 1'b0;
            Exception_Control <= 2'b00;
            abort             <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        LOAD: begin
          r_state           <= IDLE;
          busy              <= 1'b0;
          Exception_Control <= 2'b00;
        end
        default: begin
          r_state           <= IDLE;
          r_cnt             <= '0;
          mem_req           <= 1'b0;
          busy              <= 1'b0;
          Exception_Control <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer with a cycle-age reference model.
module tb_exception_sequencer;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exc_opcode = 1'b0;
  logic        exc_overflow = 1'b0;
  logic        exc_divzero = 1'b0;
  logic [31:0] pc_in = 32'd0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = 32'd0;
  logic [1:0]  Exception_Control;
  logic        mem_req;
  logic [31:0] epc_out;
  logic        epc_we;
  logic [31:0] pc_out;
  logic        pc_we;
  logic        busy;
  logic [1:0]  cause;
  logic        abort;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  exception_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .exc_opcode        (exc_opcode),
    .exc_overflow      (exc_overflow),
    .exc_divzero       (exc_divzero),
    .pc_in             (pc_in),
    .mem_ack           (mem_ack),
    .mem_data          (mem_data),
    .Exception_Control (Exception_Control),
    .mem_req           (mem_req),
    .epc_out           (epc_out),
    .epc_we            (epc_we),
    .pc_out            (pc_out),
    .pc_we             (pc_we),
    .busy              (busy),
    .cause             (cause),
    .abort             (abort)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Model: m_age counts cycles since an exception was accepted (0 = idle),
  // m_ack_at records the age at which the vector read completed.
  int          m_age = 0;
  int          m_ack_at = 0;
  logic [1:0]  m_cause = 2'b00;
  logic [31:0] m_epc = 32'd0;
  logic [31:0] m_pc = 32'd0;
  bit          m_abort = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_age = 0; m_ack_at = 0; m_cause = 2'b00;
      m_epc = 32'd0; m_pc = 32'd0; m_abort = 1'b0;
    end else begin
      m_abort = 1'b0;
      if (m_age == 0) begin
        if (exc_opcode || exc_overflow || exc_divzero) begin
          m_age    = 1;
          m_ack_at = 0;
          m_cause  = exc_opcode ? 2'd0 : (exc_overflow ? 2'd1 : 2'd2);
          m_epc    = pc_in - 32'd4;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (m_ack_at == 0) begin
        if (mem_ack) begin
          m_ack_at = m_age;
          m_pc     = mem_data % 256;
          m_age    = m_age + 1;
        end else if (m_age - 1 == TO) begin
          m_age   = 0;
          m_abort = 1'b1;
        end else begin
          m_age = m_age + 1;
        end
      end else begin
        m_age = 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_busy",    32'(busy),    32'(m_age != 0));
      chk("m_epc_we",  32'(epc_we),  32'(m_age == 1));
      chk("m_mem_req", 32'(mem_req), 32'(m_age >= 2 && m_ack_at == 0));
      chk("m_pc_we",   32'(pc_we),   32'(m_age != 0 && m_ack_at != 0));
      chk("m_abort",   32'(abort),   32'(m_abort));
      chk("m_ectl",    32'(Exception_Control), 32'((m_age != 0) ? m_cause : 2'b00));
      chk("m_cause",   32'(cause),   32'(m_cause));
      chk("m_epc",     epc_out,      m_epc);
      chk("m_pc",      pc_out,       m_pc);
    end
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n_req;
    int n_pcwe;
    int n_epcwe;
    bit got;

    // Reset state.
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ectl", 32'(Exception_Control), 32'd0);
    chk("rst_mreq", 32'(mem_req), 32'd0);
    chk("rst_epc",  epc_out, 32'd0);
    chk("rst_pc",   pc_out, 32'd0);
    cmp_en = 1'b1;
    step(); step();
    reset = 1'b1;
    step();

    // Overflow with vector read; reset-release first exception.
    pc_in = 32'h0000_0108; exc_overflow = 1'b1;
    step(); exc_overflow = 1'b0;
    chk("a_epc_we", 32'(epc_we), 32'd1);
    chk("a_epc",    epc_out, 32'h0000_0104);
    chk("a_ectl",   32'(Exception_Control), 32'd1);
    chk("a_busy",   32'(busy), 32'd1);
    step();
    chk("a_mreq",   32'(mem_req), 32'd1);
    step(); step();
    mem_ack = 1'b1; mem_data = 32'h0000_00A0;
    step(); mem_ack = 1'b0;
    chk("a_pc_we",  32'(pc_we), 32'd1);
    chk("a_pc",     pc_out, 32'h0000_00A0);
    chk("a_mreq0",  32'(mem_req), 32'd0);
    step();
    chk("a_pc_we0", 32'(pc_we), 32'd0);
    chk("a_idle",   32'(busy), 32'd0);
    chk("a_pc_hold", pc_out, 32'h0000_00A0);
    chk("a_ectl0",  32'(Exception_Control), 32'd0);

    // All three requests together: opcode wins.
    pc_in = 32'h0000_0200;
    exc_opcode = 1'b1; exc_overflow = 1'b1; exc_divzero = 1'b1;
    step(); exc_opcode = 1'b0; exc_overflow = 1'b0; exc_divzero = 1'b0;
    chk("b_cause", 32'(cause), 32'd0);
    chk("b_ectl",  32'(Exception_Control), 32'd0);
    chk("b_busy",  32'(busy), 32'd1);
    step(); mem_ack = 1'b1; mem_data = 32'h0000_0055;
    step(); mem_ack = 1'b0;
    chk("b_pc", pc_out, 32'h0000_0055);
    step();

    // Nested request ignored; ack outside REQ ignored.
    pc_in = 32'h0000_0300; exc_overflow = 1'b1; mem_ack = 1'b1; mem_data = 32'h0000_0011;
    n_epcwe = 0;
    step(); exc_overflow = 1'b0;
    if (epc_we) n_epcwe++;
    step(); mem_ack = 1'b0; exc_divzero = 1'b1;
    chk("c_mreq", 32'(mem_req), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      if (epc_we) n_epcwe++;
      chk("c_cause", 32'(cause), 32'd1);
    end
    mem_ack = 1'b1; mem_data = 32'h0000_0077;
    step(); mem_ack = 1'b0;
    if (epc_we) n_epcwe++;
    step(); exc_divzero = 1'b0;
    if (epc_we) n_epcwe++;
    chk("c_epc_we_cnt", 32'(n_epcwe), 32'd1);
    chk("c_pc",   pc_out, 32'h0000_0077);
    chk("c_idle", 32'(busy), 32'd0);
    step();

    // Timeout abort, then immediate new exception.
    pc_in = 32'h0000_0400; exc_divzero = 1'b1;
    step(); exc_divzero = 1'b0;
    n_req = 0; n_pcwe = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (abort) begin
        got = 1'b1;
        chk("d_busy_abort", 32'(busy), 32'd0);
        exc_opcode = 1'b1; pc_in = 32'h0000_0500;
        break;
      end
      if (mem_req) n_req++;
      if (pc_we) n_pcwe++;
    end
    chk("d_abort_seen", 32'(got), 32'd1);
    chk("d_req_cycles", 32'(n_req), 32'd15);
    chk("d_no_pc_we",   32'(n_pcwe), 32'd0);
    step(); exc_opcode = 1'b0;
    chk("d_next_epc_we", 32'(epc_we), 32'd1);
    chk("d_next_epc",    epc_out, 32'h0000_04FC);
    step(); mem_ack = 1'b1; mem_data = 32'h0000_0010;
    step(); mem_ack = 1'b0;
    step();

    // Ack on the final allowed REQ cycle completes without abort.
    pc_in = 32'h0000_0600; exc_divzero = 1'b1;
    step(); exc_divzero = 1'b0;
    n_req = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mem_req) begin
        n_req++;
        if (n_req == 15) begin
          mem_ack = 1'b1; mem_data = 32'h0000_00C3;
          break;
        end
      end
    end
    step(); mem_ack = 1'b0;
    chk("e_pc_we", 32'(pc_we), 32'd1);
    chk("e_abort", 32'(abort), 32'd0);
    chk("e_pc",    pc_out, 32'h0000_00C3);
    step();
    chk("e_abort2", 32'(abort), 32'd0);

    // Asynchronous reset in REQ.
    pc_in = 32'h0000_0700; exc_overflow = 1'b1;
    step(); exc_overflow = 1'b0;
    step(); step();
    #2 reset = 1'b0;
    #1;
    chk("f_mreq",  32'(mem_req), 32'd0);
    chk("f_busy",  32'(busy), 32'd0);
    chk("f_ectl",  32'(Exception_Control), 32'd0);
    chk("f_cause", 32'(cause), 32'd0);
    chk("f_epc",   epc_out, 32'd0);
    mem_ack = 1'b1; mem_data = 32'h0000_0099;
    step(); step();
    reset = 1'b1;
    n_pcwe = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (pc_we) n_pcwe++;
    end
    mem_ack = 1'b0;
    chk("f_no_pc_we", 32'(n_pcwe), 32'd0);
    chk("f_idle", 32'(busy), 32'd0);

    // EPC wrap-around and high-byte masking of the vector.
    pc_in = 32'h0000_0002; exc_divzero = 1'b1;
    step(); exc_divzero = 1'b0;
    chk("g_epc",    epc_out, 32'hFFFF_FFFE);
    chk("g_epc_we", 32'(epc_we), 32'd1);
    chk("g_ectl",   32'(Exception_Control), 32'd2);
    step(); mem_ack = 1'b1; mem_data = 32'hFFFF_FF3C;
    step(); mem_ack = 1'b0;
    chk("g_pc",    pc_out, 32'h0000_003C);
    chk("g_pc_we", 32'(pc_we), 32'd1);
    step(); step();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
